// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp sequencer: walks dc toward an accepted target in
// STEP_SIZE increments, one step every STEP_DIV clocks.
module pwm_duty_ramp #(
    parameter int STEP_DIV  = 256,
    parameter int STEP_SIZE = 1,
    parameter int MAX_DC    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       hold,
    output logic [6:0] dc,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    localparam logic [15:0] LAST = 16'(STEP_DIV - 1);
    localparam logic [7:0]  SZ   = 8'(STEP_SIZE);
    localparam logic [7:0]  MX   = 8'(MAX_DC);

    state_t      state, state_n;
    logic [15:0] presc, presc_n;
    logic [6:0]  tgt_r, tgt_n, dc_n;
    logic        done_n;
    logic        rdy;

    logic        accept;
    logic        up;
    logic [7:0]  clamp;
    logic [7:0]  dc8, tg8;
    logic [7:0]  diff, mv, nxt8;

    assign target_ready = rdy;
    assign busy         = (state == RAMP);

    always_comb begin
        state_n = state;
        presc_n = presc;
        dc_n    = dc;
        tgt_n   = tgt_r;
        done_n  = 1'b0;

        accept = target_valid & rdy;
        clamp  = ({1'b0, target} > MX) ? MX : {1'b0, target};
        dc8    = {1'b0, dc};
        tg8    = {1'b0, tgt_r};
        up     = (tg8 > dc8);
        diff   = up ? (tg8 - dc8) : (dc8 - tg8);
        // Partial final step so dc never overshoots the target
        mv     = (diff < SZ) ? diff : SZ;
        nxt8   = up ? (dc8 + mv) : (dc8 - mv);

        if (accept) begin
            tgt_n   = clamp[6:0];
            presc_n = '0;
            if (clamp == dc8) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = RAMP;
            end
        end else if (state == RAMP && !hold) begin
            if (presc == LAST) begin
                presc_n = '0;
                dc_n    = nxt8[6:0];
                if (nxt8 == tg8) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end else begin
                presc_n = presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            presc <= '0;
            dc    <= '0;
            tgt_r <= '0;
            done  <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            dc    <= dc_n;
            tgt_r <= tgt_n;
            done  <= done_n;
            rdy   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the ramp.
module tb_pwm_duty_ramp;

    localparam int DIV = 4;
    localparam int SZ  = 5;

    logic       clk;
    logic       reset;
    logic [6:0] target;
    logic       target_valid;
    logic       target_ready;
    logic       hold;
    logic [6:0] dc;
    logic       busy;
    logic       done;

    logic [6:0] target2;
    logic       valid2;
    logic       ready2;
    logic       hold2;
    logic [6:0] dc2;
    logic       busy2;
    logic       done2;

    pwm_duty_ramp #(.STEP_DIV(DIV), .STEP_SIZE(SZ), .MAX_DC(100)) dut (
        .clk(clk), .reset(reset), .target(target),
        .target_valid(target_valid), .target_ready(target_ready),
        .hold(hold), .dc(dc), .busy(busy), .done(done)
    );

    pwm_duty_ramp #(.STEP_DIV(DIV), .STEP_SIZE(50), .MAX_DC(100)) dut2 (
        .clk(clk), .reset(reset), .target(target2),
        .target_valid(valid2), .target_ready(ready2),
        .hold(hold2), .dc(dc2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: dc, target and edges elapsed in the current step interval
    int m_dc, m_tgt, m_el;
    bit m_busy, m_done, m_rdy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dc = 0; m_tgt = 0; m_el = 0;
        m_busy = 0; m_done = 0; m_rdy = 0;
    endtask

    task automatic model_edge();
        int t, d, mvv;
        if (!reset) begin
            model_reset();
            return;
        end
        if (target_valid && m_rdy) begin
            t = (int'(target) > 100) ? 100 : int'(target);
            m_tgt = t;
            m_el = 0;
            m_busy = (t != m_dc);
            m_done = (t == m_dc);
        end else begin
            m_done = 0;
            if (m_busy && !hold) begin
                m_el++;
                if (m_el == DIV) begin
                    m_el = 0;
                    d = m_tgt - m_dc;
                    mvv = (d < 0) ? -d : d;
                    if (mvv > SZ) mvv = SZ;
                    m_dc = (d > 0) ? m_dc + mvv : m_dc - mvv;
                    if (m_dc == m_tgt) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
        m_rdy = 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("dc", 32'(dc), 32'(m_dc));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("ready", 32'(target_ready), 32'(m_rdy));
    endtask

    task automatic accept(input int t);
        target = 7'(t);
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_dc", 32'(dc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(target_ready), 0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk("ready_after_rel", 32'(target_ready), 1);
    endtask

    initial begin
        reset = 1'b1;
        target = '0; target_valid = 1'b0; hold = 1'b0;
        target2 = '0; valid2 = 1'b0; hold2 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Ramp 0 -> 25
        accept(25);
        chk("up_busy_e0", 32'(busy), 1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k % DIV == 0) chk("up_dc", 32'(dc), 32'(5 * k / DIV));
            chk("up_busy", 32'(busy), 32'(k < 20));
            chk("up_done", 32'(done), 32'(k == 20));
        end
        cyc();
        chk("up_done_once", 32'(done), 0);

        // Ramp 25 -> 7 with a partial last step
        accept(7);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("no_undershoot", 32'(dc >= 7), 1);
            if (k == 4)  chk("dn_dc20", 32'(dc), 20);
            if (k == 8)  chk("dn_dc15", 32'(dc), 15);
            if (k == 12) chk("dn_dc10", 32'(dc), 10);
            if (k == 16) chk("dn_dc7", 32'(dc), 7);
            chk("dn_done", 32'(done), 32'(k == 16));
        end
        cyc();

        // Target equal to dc gives an immediate done
        accept(7);
        chk("eq_done", 32'(done), 1);
        chk("eq_busy", 32'(busy), 0);
        cyc();
        chk("eq_done_once", 32'(done), 0);

        // Retarget mid-ramp: 0 -> 50, then 10 once dc reaches 15
        do_reset();
        accept(50);
        for (int i = 0; i < 40 && dc != 7'd15; i++) cyc();
        chk("reach15", 32'(dc), 15);
        accept(10);
        chk("rt_hold15", 32'(dc), 15);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rt_dc", 32'(dc), (k < 4) ? 15 : 10);
            chk("rt_done", 32'(done), 32'(k == 4));
        end
        cyc();

        // Hold for 10 cycles mid-interval delays the step by 10
        accept(30);
        repeat (2) cyc();
        hold = 1'b1;
        repeat (10) begin
            cyc();
            chk("hold_frozen", 32'(dc), 10);
        end
        hold = 1'b0;
        cyc();
        chk("hold_pre_step", 32'(dc), 10);
        cyc();
        chk("hold_step", 32'(dc), 15);

        // Asynchronous reset mid-ramp at dc=15
        do_reset();
        chk("rst_mid_dc", 32'(dc), 0);
        accept(10);
        repeat (8) cyc();
        chk("restart_dc", 32'(dc), 10);
        chk("restart_done", 32'(done), 1);
        cyc();

        // Clamp with STEP_SIZE=50 on the second instance
        chk("d2_ready", 32'(ready2), 1);
        target2 = 7'd120;
        valid2 = 1'b1;
        cyc();
        valid2 = 1'b0;
        chk("d2_busy", 32'(busy2), 1);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 4) chk("d2_dc50", 32'(dc2), 50);
            if (k >= 8) chk("d2_dc100", 32'(dc2), 100);
            chk("d2_done", 32'(done2), 32'(k == 8));
            chk("d2_busy_k", 32'(busy2), 32'(k < 8));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            target_valid = ($urandom % 7 == 0);
            target = 7'($urandom % 128);
            hold = ($urandom % 5 == 0);
            cyc();
        end
        target_valid = 1'b0;
        hold = 1'b0;
        repeat (120) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Soft-start / soft-change duty-cycle sequencer that drives the 7-bit percent duty input (dc, 0..100) of the pwm block.
- Accepts a new target duty through a valid/ready handshake.
- Walks dc from its current value to the target in fixed-size steps, one step per programmable interval.
- Reports busy while ramping and a one-cycle done pulse on arrival, so firmware or a sequencer never has to step the PWM abruptly.

Parameters:
- STEP_DIV, 256, clock cycles between duty steps (legal range 2..65535).
- STEP_SIZE, 1, duty percent added or subtracted per step (legal range 1..100).
- MAX_DC, 100, upper clamp for target and dc.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- target  input  7  requested duty in percent. Values above MAX_DC are clamped to MAX_DC.
- target_valid  input  1  target is presented this cycle.
- target_ready  output  1  block can accept a target. Constant 1 out of reset, so retargeting mid-ramp is allowed.
- hold  input  1  freezes the ramp while high.
- dc  output  7  duty command to the pwm block; registered.
- busy  output  1  high while state is RAMP.
- done  output  1  one-cycle pulse when dc reaches target.

Behaviour:
- Reset (reset=0, asynchronous):
  - dc=0, target_r=0, prescaler=0, state=IDLE, busy=0, done=0.
  - target_ready=0 while reset is asserted; 1 from the first clk edge after release.
- Accept:
  - A target is accepted at an edge where target_valid=1 and target_ready=1. Call this edge E0.
  - target_r <= min(target, MAX_DC) and prescaler <= 0.
  - If the clamped target differs from dc: state <= RAMP.
  - If the clamped target equals dc: state <= IDLE and done=1 for the cycle after E0.
- Prescaler:
  - Counts 0..STEP_DIV-1 only in RAMP with hold=0.
  - When it equals STEP_DIV-1, the next edge is a step edge and prescaler <= 0.
  - First step therefore lands at edge E0+STEP_DIV; later steps every STEP_DIV edges.
- Step arithmetic:
  - diff = |target_r - dc|, computed on 8-bit unsigned values.
  - dc moves toward target_r by min(STEP_SIZE, diff), so there is no overshoot and a partial final step is taken when needed.
  - dc never leaves the range 0..MAX_DC.
- Arrival: the step edge that makes dc == target_r sets state <= IDLE and busy <= 0 at the same edge, and done=1 for exactly one cycle.
- States:
  - IDLE: dc stable, prescaler held at 0.
  - RAMP: stepping.
  - Transitions: IDLE->RAMP on accept with unequal target; RAMP->IDLE on arrival; RAMP->RAMP on retarget.
- Retarget mid-ramp:
  - A new accept in RAMP replaces target_r and clears the prescaler; dc is unchanged at that edge.
  - Direction is re-evaluated from the new target_r.
  - If the new target equals the current dc, go to IDLE with a done pulse.
- Accept coinciding with a step edge: the accept wins. No step is taken at that edge and the prescaler clears.
- hold:
  - While hold=1 the prescaler and dc freeze; busy stays as is.
  - Accepts are still taken; target_r updates and the prescaler clears.
  - On hold release, counting resumes from the frozen (or cleared) value.
  - hold has no effect in IDLE.
- Reset asserted mid-ramp: dc drops to 0 immediately, asynchronously, and no done pulse is produced.
- done and busy are registered, with no combinational path from the inputs.

Test Plan (STEP_DIV=4, STEP_SIZE=5 unless noted):
- Reset release -> dc=0, busy=0, done=0, target_ready=1 on the first edge after release.
- Accept target=25 at E0 -> dc takes 5,10,15,20,25 at E4, E8, E12, E16, E20; busy high E0..E19; done=1 only in the cycle after E20.
- From dc=25, accept target=7 -> dc takes 20,15,10,7, the last step being a partial step of 3; single done pulse; no undershoot below 7.
- Accept target=120 from dc=0 with STEP_SIZE=50 -> dc takes 50,100 then stops; target_r=100; done on arrival.
- Retarget: ramping 0->50, accept target=10 at the edge where dc becomes 15 -> dc stays 15 for 4 cycles, then 10, then done. Separately, target equal to current dc -> immediate done, busy=0.
- Disturbances:
  - hold=1 for 10 cycles mid-interval -> dc frozen, step delayed by exactly 10 cycles.
  - reset pulled low mid-ramp at dc=15 -> dc=0 asynchronously, no done, clean restart afterwards.
